// File: rtl/laser_interlock_pkg.sv
// Shared constants for the laser interlock sequencer.
// Contents: the state encoding (a 3-bit field that the host reads back), the
// fault vector bit indices, and a saturating 8-bit increment helper.
package laser_interlock_pkg;

  localparam int FAULT_W = 5;

  // Fault vector bit positions
  localparam int FAULT_LOWER   = 0;
  localparam int FAULT_UPPER   = 1;
  localparam int FAULT_RATE    = 2;
  localparam int FAULT_CURRENT = 3;
  localparam int FAULT_PWR     = 4;

  // State encoding, exposed on the status port
  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_POWER_UP   = 3'd1;
  localparam logic [2:0] ST_ARMED      = 3'd2;
  localparam logic [2:0] ST_TRIPPED    = 3'd3;
  localparam logic [2:0] ST_WAIT_CLEAR = 3'd4;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/interlock_cycle_timer.sv
// Cycle timer shared by the POWER_UP and TRIPPED phases of the sequencer.
// Ports:
//   clk, rst  clock and synchronous active-high reset
//   clr_i     forces the count to zero (takes priority over en_i)
//   en_i      increments the count by one
//   count_o   current count
module interlock_cycle_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || clr_i)  cnt_q <= '0;
    else if (en_i)     cnt_q <= cnt_q + 1'b1;
  end

  assign count_o = cnt_q;

endmodule

// File: rtl/laser_interlock_sequencer.sv
// Laser interlock sequencer: sequences laser power-up, latches a shutdown on
// any fault or power loss, holds the shutdown for a minimum time, and only
// releases it on a host clear with all faults gone. Captures the first fault,
// the OR of all faults seen since the trip, and a saturating trip count.
// Ports:
//   clk, rst            clk_div2 clock, synchronous active-high reset
//   fault_in[3:0]       {current, rate_lower, pulse_upper, pulse_lower} fails
//   enable_error_check  gates fault_in
//   pwr_good            laser supply good
//   laser_enable_req    host request for laser power
//   clear_fail          host clear strobe
//   laser_pwr_en, ta_shutdown, laser_ready, state   registered status/controls
//   fault_latched, first_fault, trip_count          fault capture for readback
module laser_interlock_sequencer
  import laser_interlock_pkg::*;
#(
  parameter int PWR_UP_DELAY_CYC  = 25000,
  parameter int SHUTDOWN_HOLD_CYC = 2500,
  parameter int CNT_W             = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         fault_in,
  input  logic               enable_error_check,
  input  logic               pwr_good,
  input  logic               laser_enable_req,
  input  logic               clear_fail,
  output logic               laser_pwr_en,
  output logic               ta_shutdown,
  output logic               laser_ready,
  output logic [2:0]         state,
  output logic [FAULT_W-1:0] fault_latched,
  output logic [FAULT_W-1:0] first_fault,
  output logic [7:0]         trip_count
);

  localparam logic [CNT_W-1:0] PU_LAST   = CNT_W'(PWR_UP_DELAY_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(SHUTDOWN_HOLD_CYC - 1);

  logic [2:0]         state_q, state_d;
  logic [FAULT_W-1:0] latched_q, latched_d;
  logic [FAULT_W-1:0] first_q, first_d;
  logic [7:0]         cnt_q, cnt_d;
  logic               pwr_en_q, ta_q, ready_q;

  logic [3:0]         eff_fault;
  logic [FAULT_W-1:0] trip_vec;
  logic               trip, clr_ok;
  logic               tmr_clr, tmr_en;
  logic [CNT_W-1:0]   tmr;

  assign eff_fault = fault_in & {4{enable_error_check}};

  interlock_cycle_timer #(.CNT_W(CNT_W)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (tmr_clr),
    .en_i    (tmr_en),
    .count_o (tmr)
  );

  always_comb begin
    state_d  = state_q;
    trip     = 1'b0;
    clr_ok   = 1'b0;
    // Default vector used while armed or shut down: live power loss plus faults
    trip_vec = '0;
    trip_vec[FAULT_PWR]                 = !pwr_good;
    trip_vec[FAULT_CURRENT:FAULT_LOWER] = eff_fault;
    case (state_q)
      ST_IDLE: begin
        if (laser_enable_req && pwr_good) state_d = ST_POWER_UP;
      end
      ST_POWER_UP: begin
        // Supply is allowed to settle: pwr_good only matters at the timeout
        trip_vec[FAULT_PWR] = 1'b0;
        if (!laser_enable_req) begin
          state_d = ST_IDLE;
        end else if (|eff_fault) begin
          trip = 1'b1;
        end else if (tmr == PU_LAST) begin
          if (pwr_good) state_d = ST_ARMED;
          else begin
            trip = 1'b1;
            trip_vec[FAULT_PWR] = 1'b1;
          end
        end
      end
      ST_ARMED: begin
        // A trip wins over a simultaneous request drop
        if (|trip_vec)             trip    = 1'b1;
        else if (!laser_enable_req) state_d = ST_IDLE;
      end
      ST_TRIPPED: begin
        if (tmr == HOLD_LAST) state_d = ST_WAIT_CLEAR;
      end
      ST_WAIT_CLEAR: begin
        clr_ok = clear_fail && (eff_fault == 4'b0) && pwr_good;
        if (clr_ok) state_d = ST_IDLE;
      end
      default: begin
        trip = 1'b1;
        trip_vec[FAULT_PWR] = 1'b1;
      end
    endcase
    if (trip) state_d = ST_TRIPPED;
  end

  always_comb begin
    latched_d = latched_q;
    first_d   = first_q;
    cnt_d     = cnt_q;
    if (trip) begin
      first_d   = trip_vec;
      latched_d = trip_vec;
      cnt_d     = sat_inc8(cnt_q);
    end else if (state_q == ST_TRIPPED || state_q == ST_WAIT_CLEAR) begin
      if (clr_ok) begin
        latched_d = '0;
        first_d   = '0;
      end else begin
        latched_d = latched_q | trip_vec;
      end
    end
  end

  assign tmr_clr = trip || (state_q == ST_IDLE && state_d == ST_POWER_UP);
  assign tmr_en  = (state_q == ST_POWER_UP) || (state_q == ST_TRIPPED);

  // Outputs are decoded from the next state so they change on the same edge
  // as the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      latched_q <= '0;
      first_q   <= '0;
      cnt_q     <= '0;
      pwr_en_q  <= 1'b0;
      ta_q      <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      latched_q <= latched_d;
      first_q   <= first_d;
      cnt_q     <= cnt_d;
      pwr_en_q  <= (state_d == ST_POWER_UP) || (state_d == ST_ARMED);
      ta_q      <= (state_d == ST_TRIPPED) || (state_d == ST_WAIT_CLEAR);
      ready_q   <= (state_d == ST_ARMED);
    end
  end

  assign state         = state_q;
  assign fault_latched = latched_q;
  assign first_fault   = first_q;
  assign trip_count    = cnt_q;
  assign laser_pwr_en  = pwr_en_q;
  assign ta_shutdown   = ta_q;
  assign laser_ready   = ready_q;

endmodule

// File: tb/tb_laser_interlock_sequencer.sv
module tb_laser_interlock_sequencer;

  localparam int PU   = 40;
  localparam int HOLD = 12;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] fault_in;
  logic       enable_error_check, pwr_good, laser_enable_req, clear_fail;
  logic       laser_pwr_en, ta_shutdown, laser_ready;
  logic [2:0] state;
  logic [4:0] fault_latched, first_fault;
  logic [7:0] trip_count;

  laser_interlock_sequencer #(
    .PWR_UP_DELAY_CYC(PU), .SHUTDOWN_HOLD_CYC(HOLD), .CNT_W(16)
  ) dut (
    .clk(clk), .rst(rst), .fault_in(fault_in),
    .enable_error_check(enable_error_check), .pwr_good(pwr_good),
    .laser_enable_req(laser_enable_req), .clear_fail(clear_fail),
    .laser_pwr_en(laser_pwr_en), .ta_shutdown(ta_shutdown),
    .laser_ready(laser_ready), .state(state),
    .fault_latched(fault_latched), .first_fault(first_fault),
    .trip_count(trip_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       pwr_en, ta, ready;
    logic [2:0] st;
    logic [4:0] latched, first;
    logic [7:0] cnt;
  } exp_t;

  exp_t q[$];
  int checks = 0, errors = 0;

  // Reference model: phase name plus cycles spent in the current timed phase
  typedef enum int {M_IDLE = 0, M_PWRUP = 1, M_ARMED = 2, M_TRIP = 3, M_WAIT = 4} mph_t;
  mph_t m_ph = M_IDLE;
  int   m_elapsed = 0;
  int   m_trips = 0;
  logic [4:0] m_latched = '0, m_first = '0;

  task automatic m_trip(input logic [4:0] v);
    m_ph      = M_TRIP;
    m_first   = v;
    m_latched = v;
    m_trips   = (m_trips < 255) ? m_trips + 1 : 255;
    m_elapsed = 0;
  endtask

  task automatic model_step();
    logic [3:0] ef;
    logic [4:0] live;
    ef   = enable_error_check ? fault_in : 4'b0;
    live = {~pwr_good, ef};
    if (rst) begin
      m_ph = M_IDLE; m_elapsed = 0; m_trips = 0; m_latched = '0; m_first = '0;
    end else begin
      case (m_ph)
        M_IDLE:  if (laser_enable_req && pwr_good) begin m_ph = M_PWRUP; m_elapsed = 0; end
        M_PWRUP: begin
          if (!laser_enable_req)          m_ph = M_IDLE;
          else if (ef != 0)               m_trip({1'b0, ef});
          else if (m_elapsed == PU - 1) begin
            if (pwr_good) m_ph = M_ARMED;
            else          m_trip(5'b10000);
          end else m_elapsed++;
        end
        M_ARMED: begin
          if (live != 0)              m_trip(live);
          else if (!laser_enable_req) m_ph = M_IDLE;
        end
        M_TRIP: begin
          m_latched |= live;
          if (m_elapsed == HOLD - 1) m_ph = M_WAIT;
          else m_elapsed++;
        end
        M_WAIT: begin
          if (clear_fail && ef == 0 && pwr_good) begin
            m_ph = M_IDLE; m_latched = '0; m_first = '0;
          end else m_latched |= live;
        end
        default: m_ph = M_IDLE;
      endcase
    end
  endtask

  task automatic cyc();
    exp_t e;
    model_step();
    e.pwr_en  = (m_ph == M_PWRUP) || (m_ph == M_ARMED);
    e.ta      = (m_ph == M_TRIP) || (m_ph == M_WAIT);
    e.ready   = (m_ph == M_ARMED);
    e.st      = 3'(int'(m_ph));
    e.latched = m_latched;
    e.first   = m_first;
    e.cnt     = 8'(m_trips);
    q.push_back(e);
    @(posedge clk); #2;
  endtask

  task automatic run(input int n);
    repeat (n) cyc();
  endtask

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp_v);
    end
  endtask

  // Monitor: every edge the DUT presents a new output set
  initial begin
    forever begin
      @(posedge clk); #1;
      if (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        chk("laser_pwr_en", int'(laser_pwr_en), int'(e.pwr_en));
        chk("ta_shutdown",  int'(ta_shutdown),  int'(e.ta));
        chk("laser_ready",  int'(laser_ready),  int'(e.ready));
        chk("state",        int'(state),        int'(e.st));
        chk("fault_latched",int'(fault_latched),int'(e.latched));
        chk("first_fault",  int'(first_fault),  int'(e.first));
        chk("trip_count",   int'(trip_count),   int'(e.cnt));
      end
    end
  end

  initial begin
    rst = 1'b1; fault_in = 4'b0; enable_error_check = 1'b1; pwr_good = 1'b1;
    laser_enable_req = 1'b0; clear_fail = 1'b0;
    run(3);
    rst = 1'b0;
    run(2);

    // Power-up to ARMED
    laser_enable_req = 1'b1;
    run(PU + 5);

    // Trip in ARMED on rate fault, early clear ignored, then clear
    fault_in = 4'b0100; run(1);
    fault_in = 4'b0000; run(3);
    clear_fail = 1'b1; run(1); clear_fail = 1'b0;
    run(HOLD);
    fault_in = 4'b0001; clear_fail = 1'b1; run(2);
    clear_fail = 1'b0; run(1);
    fault_in = 4'b0000; run(2);
    clear_fail = 1'b1; run(1); clear_fail = 1'b0;
    run(PU + 3);

    // Masked faults, then power loss
    enable_error_check = 1'b0; fault_in = 4'b1111; run(8);
    pwr_good = 1'b0; run(2);
    fault_in = 4'b0000; enable_error_check = 1'b1; pwr_good = 1'b1;
    run(HOLD + 2);
    clear_fail = 1'b1; laser_enable_req = 1'b0; run(1); clear_fail = 1'b0;
    run(2);

    // Power-up failure at timeout
    laser_enable_req = 1'b1; run(5);
    pwr_good = 1'b0; run(PU + 2);
    pwr_good = 1'b1; run(HOLD);
    clear_fail = 1'b1; laser_enable_req = 1'b0; run(1); clear_fail = 1'b0;
    run(2);

    // Request dropped during power-up
    laser_enable_req = 1'b1; run(10);
    laser_enable_req = 1'b0; run(3);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      laser_enable_req   = ($urandom_range(0, 99) < 97);
      pwr_good           = ($urandom_range(0, 99) < 98);
      enable_error_check = ($urandom_range(0, 99) < 90);
      fault_in           = ($urandom_range(0, 99) < 3) ? 4'($urandom) : 4'b0;
      clear_fail         = ($urandom_range(0, 99) < 20);
      rst                = ($urandom_range(0, 1999) == 0);
      cyc();
    end
    rst = 1'b0; fault_in = 4'b0; clear_fail = 1'b0; pwr_good = 1'b1;
    enable_error_check = 1'b1; laser_enable_req = 1'b0;
    run(HOLD + 2);
    clear_fail = 1'b1; run(1); clear_fail = 1'b0; run(2);

    // Trip count saturation
    laser_enable_req = 1'b1;
    for (int i = 0; i < 260; i++) begin
      fault_in = 4'b0000; run(2);
      fault_in = 4'b0001; run(1);
      fault_in = 4'b0000; run(HOLD + 2);
      clear_fail = 1'b1; run(2); clear_fail = 1'b0;
    end
    run(2);
    chk("trip_count_saturated", int'(trip_count), 255);

    // Reset while TRIPPED
    fault_in = 4'b1000; run(1);
    fault_in = 4'b0000; run(3);
    rst = 1'b1; run(1);
    rst = 1'b0; laser_enable_req = 1'b0; run(3);

    chk("scoreboard_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
